timer_array: RTL

Parametrised multi-channel timer/counter peripheral. It replaces the fixed pair of single-channel timers on the processor's device bus with one block holding `N_CH` independent channels. Each channel has a prescaler, three counting modes, a maskable sticky interrupt and write-1-to-clear status. It sits behind the system bridge on one device port, and its `irq` vector drives the CPU's `HWInt` lines starting at bit 2.

---
 rtl/timer_array_if.sv | 22 ++
 rtl/timer_array.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/timer_array_if.sv
// Register-port bundle for timer_array: word-addressed
// write strobe, combinational read data and irq vector.
interface timer_array_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [N_CH-1:0]   irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_array.sv
// timer_array: N_CH independent prescaled timer channels,
// each with one-shot/reload/free-run modes and sticky irq.
module timer_array #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
) (
  input logic          clk,
  input logic          reset,
  timer_array_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2
  } state_t;

  logic [ADDR_W-3:0] sel;
  logic [1:0]        rsel;
  logic              unused_wdata;

  assign sel          = bus.addr[ADDR_W-1:2];
  assign rsel         = bus.addr[1:0];
  assign unused_wdata = ^bus.wdata;

  logic [N_CH-1:0]  en, im, pend;
  logic [1:0]       mode   [N_CH];
  logic [3:0]       pre    [N_CH];
  logic [CNT_W-1:0] preset [N_CH];
  logic [CNT_W-1:0] count  [N_CH];
  logic [15:0]      psc    [N_CH];
  logic [15:0]      mask   [N_CH];
  state_t           st_q   [N_CH];
  state_t           st_d   [N_CH];

  logic [N_CH-1:0] wr_ctrl, wr_preset, wr_stat, en_nx;
  logic [N_CH-1:0] load, run, tick, dec;
  logic [N_CH-1:0] expire, up, wrap, os_done;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_ctrl[i]   = bus.we && sel == (ADDR_W-2)'(i)
                     && rsel == 2'd0;
      wr_preset[i] = bus.we && sel == (ADDR_W-2)'(i)
                     && rsel == 2'd1;
      wr_stat[i]   = bus.we && sel == (ADDR_W-2)'(i)
                     && rsel == 2'd3;
      en_nx[i]     = wr_ctrl[i] ? bus.wdata[0] : en[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) st_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        IDLE: if (en_nx[i]) st_d[i] = LOAD;
        LOAD: st_d[i] = en_nx[i] ? CNT : IDLE;
        CNT: begin
          if (!en_nx[i])
            st_d[i] = IDLE;
          else if (expire[i])
            st_d[i] = os_done[i] ? IDLE : LOAD;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // Prescaler free-runs in CNT; a tick fires when its low PRE bits are all ones.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mask[i]    = (16'd1 << pre[i]) - 16'd1;
      load[i]    = st_q[i] == LOAD && en_nx[i];
      run[i]     = st_q[i] == CNT && en_nx[i];
      tick[i]    = run[i] && (psc[i] & mask[i]) == mask[i];
      up[i]      = tick[i] && mode[i] == 2'b10;
      wrap[i]    = up[i] && count[i] == {CNT_W{1'b1}};
      dec[i]     = tick[i] && mode[i] != 2'b10
                   && count[i] > CNT_W'(1);
      expire[i]  = tick[i] && mode[i] != 2'b10
                   && count[i] <= CNT_W'(1);
      os_done[i] = expire[i] && mode[i] != 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= '0;
      im   <= '0;
      pend <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode[i]   <= '0;
        pre[i]    <= '0;
        preset[i] <= '0;
        count[i]  <= '0;
        psc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ctrl[i]) begin
          mode[i] <= bus.wdata[2:1];
          im[i]   <= bus.wdata[3];
          pre[i]  <= bus.wdata[7:4];
        end
        if (os_done[i])
          en[i] <= 1'b0;
        else if (wr_ctrl[i])
          en[i] <= bus.wdata[0];
        if (wr_preset[i])
          preset[i] <= bus.wdata[CNT_W-1:0];
        if (load[i])
          psc[i] <= '0;
        else if (run[i])
          psc[i] <= psc[i] + 16'd1;
        if (load[i])
          count[i] <= (preset[i] == '0) ? CNT_W'(1)
                                        : preset[i];
        else if (dec[i])
          count[i] <= count[i] - CNT_W'(1);
        else if (expire[i])
          count[i] <= '0;
        else if (up[i])
          count[i] <= count[i] + CNT_W'(1);
        // A set event on the same edge as a clear leaves it pending.
        if (expire[i] || wrap[i])
          pend[i] <= 1'b1;
        else if (wr_stat[i] && bus.wdata[0])
          pend[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == (ADDR_W-2)'(i)) begin
        unique case (rsel)
          2'd0: bus.rdata = {24'd0, pre[i], im[i],
                             mode[i], en[i]};
          2'd1: bus.rdata = 32'(preset[i]);
          2'd2: bus.rdata = 32'(count[i]);
          default: bus.rdata = {31'd0, pend[i]};
        endcase
      end
    end
  end

  assign bus.irq = pend & im;

endmodule
